// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_sequencer: iterative shift-add multiply / restoring divide into HI/LO |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module muldiv_sequencer #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Start,
  input  logic [1:0]       i_Op,
  input  logic [WIDTH-1:0] i_In1,
  input  logic [WIDTH-1:0] i_In2,
  input  logic             i_Cancel,
  input  logic             i_WrHi,
  input  logic             i_WrLo,
  input  logic [WIDTH-1:0] i_WrData,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Hi,
  output logic [WIDTH-1:0] o_Lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   in1_q, in1_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               accept;
  logic               signed_op;
  logic               op_div;
  logic               in1_neg, in2_neg;
  logic [WIDTH-1:0]   in1_mag, in2_mag;
  logic [WIDTH:0]     mul_sum, mul_acc;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   trial;
  logic               borrow;
  logic [WIDTH:0]     step_acc;
  logic [WIDTH-1:0]   step_mq;
  logic [2*WIDTH-1:0] product, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept    = i_Start && !i_Cancel && (state_q != S_BUSY);
  assign signed_op = SIGNED_EN && i_Op[1];
  assign op_div    = i_Op[0];
  assign in1_neg   = signed_op && i_In1[WIDTH-1];
  assign in2_neg   = signed_op && i_In2[WIDTH-1];
  assign in1_mag   = in1_neg ? -i_In1 : i_In1;
  assign in2_mag   = in2_neg ? -i_In2 : i_In2;

  // Multiply: conditional add keeps the carry in acc[WIDTH], then {acc,mq} >> 1.
  assign mul_sum = acc_q + {1'b0, opb_q};
  assign mul_acc = mq_q[0] ? mul_sum : acc_q;

  // Divide: {rem,quo} << 1, then trial subtract; the extra top bit is the borrow.
  assign rem_sh = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
  assign trial  = {1'b0, rem_sh} - {2'b00, opb_q};
  assign borrow = trial[WIDTH+1];

  always_comb begin
    if (is_div_q) begin
      step_acc = borrow ? rem_sh : trial[WIDTH:0];
      step_mq  = {mq_q[WIDTH-2:0], ~borrow};
    end else begin
      step_acc = {1'b0, mul_acc[WIDTH:1]};
      step_mq  = {mul_acc[0], mq_q[WIDTH-1:1]};
    end
  end

  assign product  = {step_acc[WIDTH-1:0], step_mq};
  assign prod_fix = neg_q ? -product : product;
  assign quo_fix  = neg_q ? -step_mq : step_mq;
  assign rem_fix  = rem_neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opb_d     = opb_q;
    in1_d     = in1_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_BUSY: begin
        if (i_Cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          mq_d  = step_mq;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            state_d = S_DONE;
            if (!is_div_q) begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end else if (div0_q) begin
              hi_d = in1_q;
              lo_d = '1;
            end else begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
          end
        end
      end
      default: begin
        if (accept) begin
          state_d   = S_BUSY;
          cnt_d     = '0;
          acc_d     = '0;
          // mq starts as multiplier (mul) or dividend (div); opb is the other operand.
          mq_d      = op_div ? in1_mag : in2_mag;
          opb_d     = op_div ? in2_mag : in1_mag;
          in1_d     = i_In1;
          is_div_d  = op_div;
          neg_d     = in1_neg ^ in2_neg;
          rem_neg_d = in1_neg;
          div0_d    = op_div && (i_In2 == '0);
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    if (state_q != S_BUSY) begin
      if (i_WrHi) hi_d = i_WrData;
      if (i_WrLo) lo_d = i_WrData;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opb_q     <= '0;
      in1_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opb_q     <= opb_d;
      in1_q     <= in1_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign o_Busy = (state_q == S_BUSY);
  assign o_Done = (state_q == S_DONE);
  assign o_Hi   = hi_q;
  assign o_Lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// Bench for muldiv_sequencer: scoreboard of expected {HI,LO} popped on o_Done.
module tb_muldiv_sequencer;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Start = 1'b0;
  logic [1:0]  i_Op = 2'd0;
  logic [31:0] i_In1 = '0;
  logic [31:0] i_In2 = '0;
  logic        i_Cancel = 1'b0;
  logic        i_WrHi = 1'b0;
  logic        i_WrLo = 1'b0;
  logic [31:0] i_WrData = '0;
  logic        o_Busy, o_Done;
  logic [31:0] o_Hi, o_Lo;

  muldiv_sequencer #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Op(i_Op),
    .i_In1(i_In1), .i_In2(i_In2), .i_Cancel(i_Cancel), .i_WrHi(i_WrHi),
    .i_WrLo(i_WrLo), .i_WrData(i_WrData), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_Hi(o_Hi), .o_Lo(o_Lo)
  );

  always #5 i_Clk = ~i_Clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (!op[0]) begin
      if (op[1]) res = sa * sbv;
      else       res = {32'b0, a} * {32'b0, b};
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (op[1]) begin
      q = sa / sbv;
      r = sa % sbv;
      res = {r[31:0], q[31:0]};
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
    @(negedge i_Clk);
    i_Start = 1'b1; i_Op = op; i_In1 = a; i_In2 = b;
    if (track) sb.push_back(model(op, a, b));
    @(negedge i_Clk);
    i_Start = 1'b0;
  endtask

  // Counts busy cycles until o_Done; -1 if o_Done never arrives.
  task automatic wait_done(output int busy_cycles);
    busy_cycles = 0;
    for (int k = 0; k < 200 && !o_Done; k++) begin
      if (o_Busy) busy_cycles++;
      @(negedge i_Clk);
    end
    if (!o_Done) busy_cycles = -1;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    repeat (2) @(negedge i_Clk);
    i_Reset = 1'b0;
    n_total++; if (o_Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_Busy); else n_pass++;
    n_total++; if (o_Done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_Done); else n_pass++;
    n_total++; if (o_Hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", o_Hi); else n_pass++;
    n_total++; if (o_Lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", o_Lo); else n_pass++;
  endtask

  task automatic test_arith();
    logic [1:0]  ops[9] = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd3, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [31:0] as[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000,
                            32'hDEAD_BEEF, 32'h8000_0000, 32'd7, 32'hFFFF_FFFB};
    logic [31:0] bs[9]  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF,
                            32'h0000_1234, 32'h8000_0000, 32'hFFFF_FFFE, 32'd0};
    int cyc;
    logic [63:0] e;
    for (int i = 0; i < 9; i++) begin
      start_op(ops[i], as[i], bs[i], 1'b1);
      wait_done(cyc);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      n_total++; if (cyc !== 32) $display("FAIL arith%0d_busy: got %0d cycles want 32", i, cyc); else n_pass++;
      n_total++; if (o_Hi !== e[63:32]) $display("FAIL arith%0d_hi: got %h want %h", i, o_Hi, e[63:32]); else n_pass++;
      n_total++; if (o_Lo !== e[31:0]) $display("FAIL arith%0d_lo: got %h want %h", i, o_Lo, e[31:0]); else n_pass++;
      exp_hi = e[63:32]; exp_lo = e[31:0];
      @(negedge i_Clk);
      n_total++; if (o_Done !== 1'b0) $display("FAIL arith%0d_done_pulse: got %b want 0", i, o_Done); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [63:0] e;
    start_op(2'd2, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done(cyc);
    e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    n_total++; if ({o_Hi, o_Lo} !== e) $display("FAIL b2b_first: got %h want %h", {o_Hi, o_Lo}, e); else n_pass++;
    i_Start = 1'b1; i_Op = 2'd1; i_In1 = 32'd100; i_In2 = 32'd7;
    sb.push_back(model(2'd1, 32'd100, 32'd7));
    @(negedge i_Clk);
    i_Start = 1'b0;
    n_total++; if (o_Busy !== 1'b1) $display("FAIL b2b_no_gap: got busy %b want 1", o_Busy); else n_pass++;
    wait_done(cyc);
    e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    n_total++; if (cyc !== 32) $display("FAIL b2b_busy: got %0d cycles want 32", cyc); else n_pass++;
    n_total++; if ({o_Hi, o_Lo} !== e) $display("FAIL b2b_second: got %h want %h", {o_Hi, o_Lo}, e); else n_pass++;
    exp_hi = e[63:32]; exp_lo = e[31:0];
    @(negedge i_Clk);
  endtask

  task automatic test_cancel();
    bit saw_done;
    start_op(2'd0, 32'd5, 32'd6, 1'b0);
    repeat (4) @(negedge i_Clk);
    i_Start = 1'b1; i_Op = 2'd1; i_In1 = 32'd1; i_In2 = 32'd1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    n_total++; if (o_Busy !== 1'b1) $display("FAIL cancel_start_ignored: got busy %b want 1", o_Busy); else n_pass++;
    repeat (5) @(negedge i_Clk);
    i_Cancel = 1'b1;
    @(negedge i_Clk);
    i_Cancel = 1'b0;
    n_total++; if (o_Busy !== 1'b0) $display("FAIL cancel_busy: got %b want 0", o_Busy); else n_pass++;
    n_total++; if (o_Hi !== exp_hi) $display("FAIL cancel_hi: got %h want %h", o_Hi, exp_hi); else n_pass++;
    n_total++; if (o_Lo !== exp_lo) $display("FAIL cancel_lo: got %h want %h", o_Lo, exp_lo); else n_pass++;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_Done || o_Busy) saw_done = 1'b1;
      @(negedge i_Clk);
    end
    n_total++; if (saw_done !== 1'b0) $display("FAIL cancel_no_done: got activity %b want 0", saw_done); else n_pass++;
  endtask

  task automatic test_mthi();
    int cyc;
    logic [63:0] e;
    start_op(2'd1, 32'd1000, 32'd3, 1'b1);
    repeat (3) @(negedge i_Clk);
    i_WrHi = 1'b1; i_WrData = 32'h1234;
    @(negedge i_Clk);
    i_WrHi = 1'b0;
    wait_done(cyc);
    e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    n_total++; if (o_Hi !== e[63:32]) $display("FAIL mthi_busy_ignored: got %h want %h", o_Hi, e[63:32]); else n_pass++;
    i_WrLo = 1'b1; i_WrData = 32'hABCD;
    @(negedge i_Clk);
    i_WrLo = 1'b0;
    n_total++; if (o_Lo !== 32'hABCD) $display("FAIL mtlo_in_done: got %h want 0000abcd", o_Lo); else n_pass++;
    n_total++; if (o_Hi !== e[63:32]) $display("FAIL mtlo_hi_kept: got %h want %h", o_Hi, e[63:32]); else n_pass++;
    i_WrHi = 1'b1; i_WrData = 32'h1234;
    @(negedge i_Clk);
    i_WrHi = 1'b0;
    n_total++; if (o_Hi !== 32'h1234) $display("FAIL mthi_idle: got %h want 00001234", o_Hi); else n_pass++;
    // Write and start in the same cycle: the write lands, then the result replaces it.
    @(negedge i_Clk);
    i_Start = 1'b1; i_Op = 2'd0; i_In1 = 32'd2; i_In2 = 32'd3;
    i_WrHi = 1'b1; i_WrData = 32'h5555;
    sb.push_back(model(2'd0, 32'd2, 32'd3));
    @(negedge i_Clk);
    i_Start = 1'b0; i_WrHi = 1'b0;
    n_total++; if (o_Hi !== 32'h5555) $display("FAIL mthi_with_start: got %h want 00005555", o_Hi); else n_pass++;
    wait_done(cyc);
    e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    n_total++; if ({o_Hi, o_Lo} !== e) $display("FAIL mthi_start_result: got %h want %h", {o_Hi, o_Lo}, e); else n_pass++;
    @(negedge i_Clk);
  endtask

  task automatic test_reset_mid();
    i_WrHi = 1'b1; i_WrLo = 1'b1; i_WrData = 32'h0F0F_0F0F;
    @(negedge i_Clk);
    i_WrHi = 1'b0; i_WrLo = 1'b0;
    start_op(2'd0, 32'd9, 32'd9, 1'b0);
    repeat (5) @(negedge i_Clk);
    i_Reset = 1'b1;
    @(negedge i_Clk);
    i_Reset = 1'b0;
    n_total++; if (o_Busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", o_Busy); else n_pass++;
    n_total++; if (o_Done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", o_Done); else n_pass++;
    n_total++; if (o_Hi !== 32'd0) $display("FAIL rstmid_hi: got %h want 0", o_Hi); else n_pass++;
    n_total++; if (o_Lo !== 32'd0) $display("FAIL rstmid_lo: got %h want 0", o_Lo); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_cancel();
    test_mthi();
    test_reset_mid();
    n_total++; if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
